conv_window_addr_gen: RTL and testbench

Generates feature-map read addresses for one KxK convolution layer pass in the LeNet-5 datapath. It sweeps all output positions in raster order, and within each the KxK window in raster order. Addresses go to the feature-map buffer read port; window/map boundary flags drive the downstream MAC accumulator. Started by the layer controller, reports completion back to it.

---
 rtl/conv_window_addr_gen_pkg.sv | 25 ++
 rtl/conv_window_addr_gen_axis_cnt.sv | 39 +++
 rtl/conv_window_addr_gen.sv | 123 ++++++++++++
 tb/tb_conv_window_addr_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_addr_gen_pkg.sv
// Shared definitions for the convolution window address generator:
// FSM encoding and output-geometry helpers reused by the accumulator and bench.
package conv_window_addr_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Output positions along one axis for a valid (unpadded) convolution.
   function automatic int unsigned out_dim(input int unsigned in_dim,
                                           input int unsigned k,
                                           input int unsigned stride);
      return (in_dim - k) / stride + 1;
   endfunction

   function automatic int unsigned xfers_per_pass(input int unsigned in_w,
                                                  input int unsigned in_h,
                                                  input int unsigned k,
                                                  input int unsigned stride);
      return out_dim(in_w, k, stride) * out_dim(in_h, k, stride) * k * k;
   endfunction

endpackage

// File: rtl/conv_window_addr_gen_axis_cnt.sv
// One wrapping axis counter of the window sweep; instances chain through carry_c.
// count_nxt_c exposes the next count so the parent can register outputs from it.
module win_axis_cnt #(
   parameter int unsigned LIMIT = 2,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             global_rst_n,
   input  logic             ce,
   input  logic             clr,
   output logic [CNT_W-1:0] count_nxt_c,
   output logic             carry_c
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             at_max;

   always_comb begin
      at_max  = (count_q == CNT_W'(LIMIT - 1));
      carry_c = ce && at_max;
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (ce) begin
         count_d = at_max ? '0 : count_q + CNT_W'(1);
      end
      count_nxt_c = count_d;
   end

   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Feature-map read address sweep for one KxK convolution pass: output positions
// in raster order, KxK taps per position, with window/map boundary flags.
module conv_window_addr_gen
   import conv_window_addr_gen_pkg::*;
#(
   parameter int unsigned IN_W   = 32,
   parameter int unsigned IN_H   = 32,
   parameter int unsigned K      = 5,
   parameter int unsigned STRIDE = 1,
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned CNT_W  = 6
) (
   input  logic              clk,
   input  logic              global_rst_n,
   input  logic              i_start,
   input  logic              i_clear,
   input  logic              i_ready,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_valid,
   output logic              o_win_last,
   output logic              o_last,
   output logic              o_busy,
   output logic              o_done
);

   localparam int unsigned OUT_W = out_dim(IN_W, K, STRIDE);
   localparam int unsigned OUT_H = out_dim(IN_H, K, STRIDE);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] o_addr_q, o_addr_d;
   logic              o_valid_q, o_valid_d;
   logic              o_win_last_q, o_win_last_d;
   logic              o_last_q, o_last_d;
   logic              o_busy_q, o_busy_d;
   logic              o_done_q, o_done_d;

   logic              kx_ce, cnt_clr, run_d;
   logic              kx_carry, ky_carry, ox_carry, oy_carry;
   logic [CNT_W-1:0]  kx_n, ky_n, ox_n, oy_n;
   logic [31:0]       addr_full;

   // kx innermost, oy outermost; each stage advances on the carry of the one inside it.
   win_axis_cnt #(.LIMIT(K), .CNT_W(CNT_W)) u_kx (
      .clk(clk), .global_rst_n(global_rst_n), .ce(kx_ce), .clr(cnt_clr),
      .count_nxt_c(kx_n), .carry_c(kx_carry));
   win_axis_cnt #(.LIMIT(K), .CNT_W(CNT_W)) u_ky (
      .clk(clk), .global_rst_n(global_rst_n), .ce(kx_carry), .clr(cnt_clr),
      .count_nxt_c(ky_n), .carry_c(ky_carry));
   win_axis_cnt #(.LIMIT(OUT_W), .CNT_W(CNT_W)) u_ox (
      .clk(clk), .global_rst_n(global_rst_n), .ce(ky_carry), .clr(cnt_clr),
      .count_nxt_c(ox_n), .carry_c(ox_carry));
   win_axis_cnt #(.LIMIT(OUT_H), .CNT_W(CNT_W)) u_oy (
      .clk(clk), .global_rst_n(global_rst_n), .ce(ox_carry), .clr(cnt_clr),
      .count_nxt_c(oy_n), .carry_c(oy_carry));

   always_comb begin
      state_d = state_q;
      cnt_clr = 1'b0;
      kx_ce   = (state_q == ST_RUN) && o_valid_q && i_ready;

      case (state_q)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (i_start) state_d = ST_RUN;
         end
         ST_RUN: begin
            // The carry out of oy is exactly a transfer of the final tap.
            if (oy_carry) state_d = ST_DONE;
         end
         ST_DONE: begin
            cnt_clr = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            cnt_clr = 1'b1;
            state_d = ST_IDLE;
         end
      endcase

      if (i_clear) begin
         cnt_clr = 1'b1;
         state_d = ST_IDLE;
      end

      // Outputs are registered from the next counter values, so they hold while stalled.
      run_d        = (state_d == ST_RUN);
      addr_full    = (32'(oy_n) * STRIDE + 32'(ky_n)) * IN_W + 32'(ox_n) * STRIDE + 32'(kx_n);
      o_addr_d     = run_d ? ADDR_W'(addr_full) : '0;
      o_win_last_d = run_d && (kx_n == CNT_W'(K - 1)) && (ky_n == CNT_W'(K - 1));
      o_last_d     = o_win_last_d && (ox_n == CNT_W'(OUT_W - 1)) && (oy_n == CNT_W'(OUT_H - 1));
      o_valid_d    = run_d;
      o_busy_d     = run_d;
      o_done_d     = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         state_q      <= ST_IDLE;
         o_addr_q     <= '0;
         o_valid_q    <= 1'b0;
         o_win_last_q <= 1'b0;
         o_last_q     <= 1'b0;
         o_busy_q     <= 1'b0;
         o_done_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         o_addr_q     <= o_addr_d;
         o_valid_q    <= o_valid_d;
         o_win_last_q <= o_win_last_d;
         o_last_q     <= o_last_d;
         o_busy_q     <= o_busy_d;
         o_done_q     <= o_done_d;
      end
   end

   assign o_addr     = o_addr_q;
   assign o_valid    = o_valid_q;
   assign o_win_last = o_win_last_q;
   assign o_last     = o_last_q;
   assign o_busy     = o_busy_q;
   assign o_done     = o_done_q;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Bench for conv_window_addr_gen: a 6x6/K3/S1 instance and a 6x6/K2/S2 instance
// checked against a nested-loop address model under random backpressure.
module tb_conv_window_addr_gen;

   localparam int unsigned AW = 10;
   localparam int unsigned CW = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic global_rst_n, start, clear, ready, sel;
   logic a_start, a_clear, a_ready, b_start, b_clear, b_ready;
   logic [AW-1:0] a_addr, b_addr, addr;
   logic a_valid, a_wl, a_last, a_busy, a_done;
   logic b_valid, b_wl, b_last, b_busy, b_done;
   logic valid, win_last, last, busy, done;

   assign a_start = start & ~sel;
   assign a_clear = clear & ~sel;
   assign a_ready = ready & ~sel;
   assign b_start = start & sel;
   assign b_clear = clear & sel;
   assign b_ready = ready & sel;

   assign addr     = sel ? b_addr  : a_addr;
   assign valid    = sel ? b_valid : a_valid;
   assign win_last = sel ? b_wl    : a_wl;
   assign last     = sel ? b_last  : a_last;
   assign busy     = sel ? b_busy  : a_busy;
   assign done     = sel ? b_done  : a_done;

   conv_window_addr_gen #(.IN_W(6), .IN_H(6), .K(3), .STRIDE(1), .ADDR_W(AW), .CNT_W(CW)) u_dut_a (
      .clk(clk), .global_rst_n(global_rst_n), .i_start(a_start), .i_clear(a_clear),
      .i_ready(a_ready), .o_addr(a_addr), .o_valid(a_valid), .o_win_last(a_wl),
      .o_last(a_last), .o_busy(a_busy), .o_done(a_done));

   conv_window_addr_gen #(.IN_W(6), .IN_H(6), .K(2), .STRIDE(2), .ADDR_W(AW), .CNT_W(CW)) u_dut_b (
      .clk(clk), .global_rst_n(global_rst_n), .i_start(b_start), .i_clear(b_clear),
      .i_ready(b_ready), .o_addr(b_addr), .o_valid(b_valid), .o_win_last(b_wl),
      .o_last(b_last), .o_busy(b_busy), .o_done(b_done));

   int checks = 0;
   int passed = 0;

   int unsigned exp_addr[$];
   bit          exp_wl[$];
   bit          exp_last[$];
   int unsigned got_addr[$];
   bit          got_wl[$];
   bit          got_last[$];
   int unsigned ref_addr[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Reference sweep written straight from the address formula.
   task automatic build_model(input int in_w, input int in_h, input int k, input int s);
      int ow, oh;
      ow = (in_w - k) / s + 1;
      oh = (in_h - k) / s + 1;
      exp_addr.delete(); exp_wl.delete(); exp_last.delete();
      for (int oy = 0; oy < oh; oy++)
         for (int ox = 0; ox < ow; ox++)
            for (int ky = 0; ky < k; ky++)
               for (int kx = 0; kx < k; kx++) begin
                  exp_addr.push_back(int'(((oy * s + ky) * in_w + ox * s + kx) % 1024));
                  exp_wl.push_back(kx == k - 1 && ky == k - 1);
                  exp_last.push_back(kx == k - 1 && ky == k - 1 && ox == ow - 1 && oy == oh - 1);
               end
   endtask

   task automatic compare_model(input string tag);
      int err;
      err = 0;
      check({tag, "_len"}, got_addr.size(), exp_addr.size());
      for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
         if (got_addr[i] != exp_addr[i] || got_wl[i] != exp_wl[i] || got_last[i] != exp_last[i])
            err++;
      check({tag, "_seq_errs"}, err, 0);
   endtask

   // Runs one pass from IDLE; called at a negedge with the selected DUT idle.
   task automatic run_pass(input bit bp, input bit poke, input int clear_at, output int nx);
      bit pv, pr, pwl, pl, fin;
      logic [AW-1:0] pa;
      int stall_err;
      got_addr.delete(); got_wl.delete(); got_last.delete();
      nx = 0; stall_err = 0; fin = 0;
      check("idle_valid", valid, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("valid_after_start", valid, 1);
      check("busy_after_start", busy, 1);
      for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
         if (clear_at >= 0 && nx == clear_at) begin
            clear = 1'b1;
            ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            clear = 1'b0;
            check("clear_valid", valid, 0);
            check("clear_busy", busy, 0);
            check("clear_addr", addr, 0);
            check("clear_flags", {win_last, last}, 0);
            check("clear_done", done, 0);
            @(negedge clk);
            check("clear_no_done_later", done, 0);
            fin = 1;
         end else begin
            ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            start = poke && (nx == 10);
            pv = valid; pr = ready; pa = addr; pwl = win_last; pl = last;
            if (valid && ready) begin
               got_addr.push_back(int'(addr));
               got_wl.push_back(win_last);
               got_last.push_back(last);
               nx++;
            end
            @(negedge clk);
            start = 1'b0;
            if (pv && !pr && (valid !== 1'b1 || addr !== pa || win_last !== pwl || last !== pl))
               stall_err++;
            if (pv && pr && pl) begin
               check("done_after_last", done, 1);
               check("valid_drops_after_last", valid, 0);
               check("busy_drops_after_last", busy, 0);
               start = poke;
               @(negedge clk);
               start = 1'b0;
               check("done_one_cycle", done, 0);
               check("no_restart", valid, 0);
               check("idle_flags", {win_last, last}, 0);
               fin = 1;
            end
         end
      end
      check("pass_finished", fin, 1);
      if (bp) check("stall_stable_errs", stall_err, 0);
   endtask

   int nx;
   int err;
   int n_last;
   int unsigned first18[18] = '{0, 1, 2, 6, 7, 8, 12, 13, 14, 1, 2, 3, 7, 8, 9, 13, 14, 15};
   int unsigned b_win[8]    = '{2, 3, 8, 9, 28, 29, 34, 35};

   initial begin
      global_rst_n = 1'b0; start = 1'b0; clear = 1'b0; ready = 1'b0; sel = 1'b0;
      #12;
      check("rst_a_outputs", {a_addr, a_valid, a_wl, a_last, a_busy, a_done}, 0);
      check("rst_b_outputs", {b_addr, b_valid, b_wl, b_last, b_busy, b_done}, 0);
      @(negedge clk);
      global_rst_n = 1'b1;
      @(negedge clk);

      // K=3, stride 1, ready tied high
      build_model(6, 6, 3, 1);
      run_pass(0, 0, -1, nx);
      check("a_xfers", nx, 144);
      compare_model("a_tied");
      for (int i = 0; i < 18; i++) check($sformatf("a_addr_%0d", i), got_addr[i], first18[i]);
      check("a_win_last_tap8", got_wl[8], 1);
      check("a_win_last_tap7", got_wl[7], 0);
      check("a_final_addr", got_addr[143], 35);
      check("a_final_last", got_last[143], 1);
      n_last = 0;
      foreach (got_last[i]) n_last += int'(got_last[i]);
      check("a_single_last", n_last, 1);
      ref_addr = got_addr;

      // Random backpressure must not change the sequence
      run_pass(1, 0, -1, nx);
      check("a_bp_xfers", nx, 144);
      compare_model("a_bp");
      err = 0;
      for (int i = 0; i < got_addr.size() && i < ref_addr.size(); i++)
         if (got_addr[i] != ref_addr[i]) err++;
      check("a_bp_vs_tied_errs", err, 0);

      // Start pulses in RUN and in DONE are ignored
      run_pass(0, 1, -1, nx);
      check("a_poke_xfers", nx, 144);
      compare_model("a_poke");

      // Abort at transfer 50, then restart from address 0
      run_pass(1, 0, 50, nx);
      check("a_clear_xfers", nx, 50);
      run_pass(0, 0, -1, nx);
      check("a_restart_first", got_addr[0], 0);
      check("a_restart_xfers", nx, 144);
      compare_model("a_restart");

      // K=2, stride 2
      sel = 1'b1;
      build_model(6, 6, 2, 2);
      run_pass(1, 0, -1, nx);
      check("b_xfers", nx, 36);
      compare_model("b_bp");
      for (int i = 0; i < 4; i++) check($sformatf("b_win_ox1_%0d", i), got_addr[4 + i], b_win[i]);
      for (int i = 0; i < 4; i++) check($sformatf("b_win_last_%0d", i), got_addr[32 + i], b_win[4 + i]);
      check("b_final_last", got_last[35], 1);

      // Asynchronous reset mid-run
      sel = 1'b0;
      build_model(6, 6, 3, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ready = 1'b1;
      repeat (20) @(negedge clk);
      #2 global_rst_n = 1'b0;
      #1;
      check("async_rst_outputs", {a_addr, a_valid, a_wl, a_last, a_busy, a_done}, 0);
      @(negedge clk);
      global_rst_n = 1'b1;
      @(negedge clk);
      run_pass(0, 0, -1, nx);
      check("post_rst_xfers", nx, 144);
      compare_model("post_rst");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
